// File: rtl/sha512_pkg.sv
// Shared definitions for the SHA2-512 front end.
//   SHA512_BLK_W   : message block width in bits
//   SHA512_WORDS32 : 32-bit words per message block
//   SHA512_LEN_OFS : byte offset of the 128-bit length field within a block
//   pad_state_e    : padder FSM states
//   pad_pend_e     : work still owed after the current block is emitted
//   bswap32        : bus (little-endian byte lanes) to big-endian word
package sha512_pkg;

  localparam int unsigned SHA512_BLK_W   = 1024;
  localparam int unsigned SHA512_WORDS32 = 32;
  localparam int unsigned SHA512_LEN_OFS = 112;

  typedef enum logic [1:0] {
    StFill,
    StEmit,
    StFinal
  } pad_state_e;

  typedef enum logic [1:0] {
    PendNone,
    PendLen,
    PendPad80
  } pad_pend_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha512_pad_lane.sv
// Input word formatter for sha512_pad (combinational).
//   in_data   : bus word, first message byte in [7:0]
//   in_nbytes : number of valid bytes (0..4)
//   in_last   : word ends the message
//   be_word   : big-endian word, invalid lanes zeroed, 0x80 placed right after
//               the data when the message ends inside this word
module sha512_pad_lane
  import sha512_pkg::*;
(
  input  logic [31:0] in_data,
  input  logic [2:0]  in_nbytes,
  input  logic        in_last,
  output logic [31:0] be_word
);

  logic [31:0] swapped;
  int          nb;

  always_comb begin
    swapped = bswap32(in_data);
    nb      = int'({29'd0, in_nbytes});
    be_word = '0;
    for (int i = 0; i < 4; i++) begin
      // Lane i holds message byte i of this word, MSB first.
      if (i < nb) begin
        be_word[31-8*i -: 8] = swapped[31-8*i -: 8];
      end else if (in_last && (i == nb)) begin
        be_word[31-8*i -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha512_pad.sv
// SHA-512 message padder: packs 32-bit bus words into 1024-bit big-endian
// blocks, appends 0x80, zero fill and the 128-bit message bit length.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input word handshake
//   in_data/in_nbytes     : bus word (byte 0 in [7:0]) and valid byte count
//   in_last               : word ends the message
//   blk_valid/blk_ready   : output block handshake
//   blk_data              : block, message byte 0 at [1023:1016]
//   blk_last              : final block of the message
module sha512_pad
  import sha512_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_data,
  input  logic [2:0]              in_nbytes,
  input  logic                    in_last,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [SHA512_BLK_W-1:0] blk_data,
  output logic                    blk_last
);

  // First buffer word of the length field.
  localparam logic [4:0] LenWord = 5'(SHA512_LEN_OFS / 4);

  logic [31:0]      buf_q [SHA512_WORDS32];
  logic [4:0]       wp_q;
  logic [LEN_W-1:0] len_q;
  pad_state_e       state_q;
  pad_pend_e        pend_q;
  logic             last_q;

  logic [31:0]      lane_word;
  logic [LEN_W-1:0] len_next;
  logic [127:0]     len_fill;
  logic [127:0]     len_cur;
  logic [7:0]       pos;
  logic             in_fire;
  logic             blk_fire;

  sha512_pad_lane u_lane (
    .in_data   (in_data),
    .in_nbytes (in_nbytes),
    .in_last   (in_last),
    .be_word   (lane_word)
  );

  assign in_ready  = (state_q == StFill);
  assign blk_valid = (state_q != StFill);
  assign blk_last  = last_q;
  assign in_fire   = in_valid && in_ready;
  assign blk_fire  = blk_valid && blk_ready;

  // Length including the word being accepted, and the byte position after it.
  assign len_next = len_q + LEN_W'({in_nbytes, 3'b000});
  assign len_fill = 128'(len_next);
  assign len_cur  = 128'(len_q);
  assign pos      = {1'b0, wp_q, 2'b00} + {5'd0, in_nbytes};

  always_comb begin
    blk_data = '0;
    for (int i = 0; i < SHA512_WORDS32; i++) begin
      blk_data[SHA512_BLK_W-1-32*i -: 32] = buf_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      pend_q  <= PendNone;
      last_q  <= 1'b0;
      wp_q    <= '0;
      len_q   <= '0;
      for (int i = 0; i < SHA512_WORDS32; i++) buf_q[i] <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (in_fire) begin
            buf_q[wp_q] <= lane_word;
            len_q       <= len_next;
            if (in_last) begin
              state_q <= StEmit;
              // A full last word pushes the 0x80 marker into the next word.
              if ((in_nbytes == 3'd4) && (wp_q != 5'd31)) begin
                buf_q[wp_q + 5'd1] <= 32'h8000_0000;
              end
              if (pos < 8'(SHA512_LEN_OFS)) begin
                buf_q[LenWord]        <= len_fill[127:96];
                buf_q[LenWord + 5'd1] <= len_fill[95:64];
                buf_q[LenWord + 5'd2] <= len_fill[63:32];
                buf_q[LenWord + 5'd3] <= len_fill[31:0];
                last_q <= 1'b1;
                pend_q <= PendNone;
              end else if (pos < 8'd128) begin
                last_q <= 1'b0;
                pend_q <= PendLen;
              end else begin
                last_q <= 1'b0;
                pend_q <= PendPad80;
              end
            end else if (wp_q == 5'd31) begin
              state_q <= StEmit;
              last_q  <= 1'b0;
              pend_q  <= PendNone;
            end else begin
              wp_q <= wp_q + 5'd1;
            end
          end
        end

        StEmit: begin
          if (blk_fire) begin
            for (int i = 0; i < SHA512_WORDS32; i++) buf_q[i] <= '0;
            wp_q   <= '0;
            pend_q <= PendNone;
            if (pend_q == PendNone) begin
              if (last_q) len_q <= '0;
              last_q  <= 1'b0;
              state_q <= StFill;
            end else begin
              // Extra block: length only, preceded by 0x80 if the data ended flush.
              if (pend_q == PendPad80) buf_q[0] <= 32'h8000_0000;
              buf_q[LenWord]        <= len_cur[127:96];
              buf_q[LenWord + 5'd1] <= len_cur[95:64];
              buf_q[LenWord + 5'd2] <= len_cur[63:32];
              buf_q[LenWord + 5'd3] <= len_cur[31:0];
              last_q  <= 1'b1;
              state_q <= StFinal;
            end
          end
        end

        StFinal: begin
          if (blk_fire) begin
            for (int i = 0; i < SHA512_WORDS32; i++) buf_q[i] <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
            state_q <= StFill;
          end
        end

        default: begin
          state_q <= StFill;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha512_pad.sv
// Directed self-checking bench for sha512_pad.
module tb_sha512_pad;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic [2:0]    in_nbytes = '0;
  logic          in_last = 1'b0;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [1023:0] blk_data;
  logic          blk_last;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sha512_pad #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_nbytes (in_nbytes),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
  );

  // Stimulus must stay within the legal input protocol.
  always @(posedge clk) begin
    if (rst_n && in_valid) begin
      assert (in_nbytes <= 3'd4 && (in_last || in_nbytes == 3'd4))
        else $error("illegal input word nbytes=%0d last=%b", in_nbytes, in_last);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] mb(input int j);
    return 8'((j * 13 + 7) & 255);
  endfunction

  // Bus word for message bytes j0.., invalid lanes filled with 0xEE.
  function automatic logic [31:0] bus_word(input int j0, input int nb);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = (k < nb) ? mb(j0 + k) : 8'hEE;
    return w;
  endfunction

  function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
    for (int i = 0; i < 32; i++) if (a[1023-32*i -: 32] !== b[1023-32*i -: 32]) return i;
    return 0;
  endfunction

  function automatic logic [1023:0] abc_block();
    logic [1023:0] b;
    b = '0;
    b[1023:992] = 32'h6162_6380;
    b[63:0]     = 64'h18;
    return b;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_nbytes = nb; in_last = last;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input int n);
    int nw;
    int nb;
    if (n == 0) begin
      send_word(32'hEEEE_EEEE, 3'd0, 1'b1);
    end else begin
      nw = (n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
        nb = (w == nw - 1) ? n - 4 * w : 4;
        send_word(bus_word(4 * w, nb), 3'(nb), w == nw - 1);
      end
    end
  endtask

  task automatic recv_block(output logic [1023:0] d, output logic l);
    int n = 0;
    while (!blk_valid && n < 200) begin @(posedge clk); #1; n++; end
    if (!blk_valid) begin
      total++; bad++;
      $display("FAIL recv_timeout blk_valid=%b want 1", blk_valid);
      d = '0; l = 1'b0;
    end else begin
      d = blk_data; l = blk_last;
      blk_ready = 1'b1;
      @(posedge clk); #1;
      blk_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL reset_blk_valid got %b want 0", blk_valid); end
    total++; if (blk_last !== 1'b0) begin bad++; $display("FAIL reset_blk_last got %b want 0", blk_last); end
    total++; if (blk_data !== '0) begin
      bad++; $display("FAIL reset_blk_data word %0d got %h want 0", first_diff(blk_data, '0),
                      blk_data[1023-32*first_diff(blk_data, '0) -: 32]);
    end
  endtask

  task automatic test_abc();
    logic [1023:0] d, want;
    logic l;
    int w;
    want = abc_block();
    send_word(32'h0063_6261, 3'd3, 1'b1);
    total++; if (blk_valid !== 1'b1) begin bad++; $display("FAIL abc_latency blk_valid got %b want 1", blk_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abc_in_ready got %b want 0", in_ready); end
    recv_block(d, l);
    total++; if (d !== want) begin
      w = first_diff(d, want);
      bad++; $display("FAIL abc_data word %0d got %h want %h", w, d[1023-32*w -: 32], want[1023-32*w -: 32]);
    end
    total++; if (l !== 1'b1) begin bad++; $display("FAIL abc_last got %b want 1", l); end
    total++; if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL abc_after valid/ready got %b/%b want 0/1", blk_valid, in_ready);
    end
  endtask

  task automatic test_empty();
    logic [1023:0] d, want;
    logic l;
    int w;
    want = '0;
    want[1023:1016] = 8'h80;
    send_msg(0);
    recv_block(d, l);
    total++; if (d !== want) begin
      w = first_diff(d, want);
      bad++; $display("FAIL empty_data word %0d got %h want %h", w, d[1023-32*w -: 32], want[1023-32*w -: 32]);
    end
    total++; if (l !== 1'b1) begin bad++; $display("FAIL empty_last got %b want 1", l); end
  endtask

  // 111 bytes: marker lands at byte 111, the last byte before the length field.
  task automatic test_111();
    logic [1023:0] d, want;
    logic l;
    int w;
    want = '0;
    for (int j = 0; j < 111; j++) want[1023-8*j -: 8] = mb(j);
    want[1023-8*111 -: 8] = 8'h80;
    want[63:0] = 64'h378;
    send_msg(111);
    recv_block(d, l);
    total++; if (d !== want) begin
      w = first_diff(d, want);
      bad++; $display("FAIL m111_data word %0d got %h want %h", w, d[1023-32*w -: 32], want[1023-32*w -: 32]);
    end
    total++; if (l !== 1'b1) begin bad++; $display("FAIL m111_last got %b want 1", l); end
    @(posedge clk); #1;
    total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL m111_extra_block got %b want 0", blk_valid); end
  endtask

  task automatic test_112();
    logic [1023:0] d, want;
    logic l;
    int w;
    want = '0;
    for (int j = 0; j < 112; j++) want[1023-8*j -: 8] = mb(j);
    want[1023-8*112 -: 8] = 8'h80;
    send_msg(112);
    recv_block(d, l);
    total++; if (d !== want) begin
      w = first_diff(d, want);
      bad++; $display("FAIL m112_blk1 word %0d got %h want %h", w, d[1023-32*w -: 32], want[1023-32*w -: 32]);
    end
    total++; if (l !== 1'b0) begin bad++; $display("FAIL m112_blk1_last got %b want 0", l); end
    want = '0;
    want[63:0] = 64'h380;
    recv_block(d, l);
    total++; if (d !== want) begin
      w = first_diff(d, want);
      bad++; $display("FAIL m112_blk2 word %0d got %h want %h", w, d[1023-32*w -: 32], want[1023-32*w -: 32]);
    end
    total++; if (l !== 1'b1) begin bad++; $display("FAIL m112_blk2_last got %b want 1", l); end
  endtask

  task automatic test_128();
    logic [1023:0] d, want;
    logic l;
    int w;
    want = '0;
    for (int j = 0; j < 128; j++) want[1023-8*j -: 8] = mb(j);
    send_msg(128);
    recv_block(d, l);
    total++; if (d !== want) begin
      w = first_diff(d, want);
      bad++; $display("FAIL m128_blk1 word %0d got %h want %h", w, d[1023-32*w -: 32], want[1023-32*w -: 32]);
    end
    total++; if (l !== 1'b0) begin bad++; $display("FAIL m128_blk1_last got %b want 0", l); end
    want = '0;
    want[1023:1016] = 8'h80;
    want[63:0] = 64'h400;
    recv_block(d, l);
    total++; if (d !== want) begin
      w = first_diff(d, want);
      bad++; $display("FAIL m128_blk2 word %0d got %h want %h", w, d[1023-32*w -: 32], want[1023-32*w -: 32]);
    end
    total++; if (l !== 1'b1) begin bad++; $display("FAIL m128_blk2_last got %b want 1", l); end
    // Length counter must restart from zero for the next message.
    want = abc_block();
    send_word(32'h0063_6261, 3'd3, 1'b1);
    recv_block(d, l);
    total++; if (d !== want) begin
      w = first_diff(d, want);
      bad++; $display("FAIL m128_then_abc word %0d got %h want %h", w, d[1023-32*w -: 32], want[1023-32*w -: 32]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1023:0] d, want, held;
    logic l;
    int w;
    int stall_bad = 0;
    want = abc_block();
    send_word(32'h0063_6261, 3'd3, 1'b1);
    held = blk_data;
    // Next message word waits while the block is stalled.
    in_valid = 1'b1; in_data = 32'h0063_6261; in_nbytes = 3'd3; in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (blk_data !== held || blk_last !== 1'b1 || blk_valid !== 1'b1 || in_ready !== 1'b0)
        stall_bad++;
    end
    total++; if (stall_bad != 0) begin
      bad++; $display("FAIL stall_hold got %0d bad cycles want 0", stall_bad);
    end
    total++; if (held !== want) begin
      w = first_diff(held, want);
      bad++; $display("FAIL stall_data word %0d got %h want %h", w, held[1023-32*w -: 32], want[1023-32*w -: 32]);
    end
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
    total++; if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release valid/ready got %b/%b want 0/1", blk_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    total++; if (blk_valid !== 1'b1) begin bad++; $display("FAIL stall_word_taken blk_valid got %b want 1", blk_valid); end
    recv_block(d, l);
    total++; if (d !== want || l !== 1'b1) begin
      w = first_diff(d, want);
      bad++; $display("FAIL stall_second word %0d got %h want %h last %b", w, d[1023-32*w -: 32],
                      want[1023-32*w -: 32], l);
    end
    @(posedge clk); #1;
    total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL stall_dup_block got %b want 0", blk_valid); end
  endtask

  task automatic test_reset_mid();
    logic [1023:0] d, want;
    logic l;
    int w;
    want = abc_block();
    for (int k = 0; k < 5; k++) send_word(bus_word(4 * k, 4), 3'd4, 1'b0);
    rst_n = 1'b0; #1;
    total++; if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_fill valid/ready got %b/%b want 0/1", blk_valid, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // Reset while a block is being offered.
    send_word(32'h0063_6261, 3'd3, 1'b1);
    rst_n = 1'b0; #1;
    total++; if (blk_valid !== 1'b0 || in_ready !== 1'b1 || blk_data !== '0) begin
      bad++; $display("FAIL rstmid_emit valid/ready got %b/%b want 0/1", blk_valid, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_word(32'h0063_6261, 3'd3, 1'b1);
    recv_block(d, l);
    total++; if (d !== want || l !== 1'b1) begin
      w = first_diff(d, want);
      bad++; $display("FAIL rstmid_abc word %0d got %h want %h last %b", w, d[1023-32*w -: 32],
                      want[1023-32*w -: 32], l);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_111();
    test_112();
    test_128();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
